// File: rtl/alu32_issue_pipe.sv
// alu32_issue_pipe: FIFO-buffered issue stage feeding a 32-bit ALU,
// with a registered, handshaked retire stage and an overflow counter.
//
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready - operation handshake (in_A, in_B, in_control)
//   out_valid/ready   - result handshake (out_result and flags)
//   ovf_count         - saturating count of overflowing results
//   busy              - work queued or a result still held

module alu32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  control,
    output logic [31:0] out,
    output logic        overflow,
    output logic        zero,
    output logic        negative
);
    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        out      = '0;
        overflow = 1'b0;
        case (control)
            3'd2: begin
                out      = sum;
                overflow = (a[31] == b[31]) &&
                           (sum[31] != a[31]);
            end
            3'd3: begin
                out      = diff;
                overflow = (a[31] != b[31]) &&
                           (diff[31] != a[31]);
            end
            3'd4: out = a & b;
            3'd5: out = a | b;
            3'd6: out = ~(a | b);
            3'd7: out = a ^ b;
            default: out = '0;
        endcase
    end

    assign zero     = (out == '0);
    assign negative = out[31];
endmodule

module alu32_issue_pipe #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_A,
    input  logic [31:0]      in_B,
    input  logic [2:0]       in_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             out_negative,
    output logic [CNT_W-1:0] ovf_count,
    output logic             busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULLC = DEPTH[AW:0];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
    } op_t;

    op_t           mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    logic        full;
    logic        empty;
    logic        push;
    logic        load;
    op_t         head;
    logic [31:0] alu_out;
    logic        alu_ovf;
    logic        alu_zero;
    logic        alu_neg;

    assign full     = (count == FULLC);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    // A held result frees the output stage in the same cycle it is taken.
    assign load     = !empty && (!out_valid || out_ready);
    assign head     = mem[rptr];
    assign busy     = !empty || out_valid;

    alu32 u_alu (
        .a        (head.a),
        .b        (head.b),
        .control  (head.ctrl),
        .out      (alu_out),
        .overflow (alu_ovf),
        .zero     (alu_zero),
        .negative (alu_neg)
    );

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= '{a: in_A, b: in_B, ctrl: in_control};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_negative <= 1'b0;
            ovf_count    <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (load) begin
                rptr         <= rptr + 1'b1;
                out_valid    <= 1'b1;
                out_result   <= alu_out;
                out_overflow <= alu_ovf;
                out_zero     <= alu_zero;
                out_negative <= alu_neg;
                if (alu_ovf && ovf_count != '1) begin
                    ovf_count <= ovf_count + 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (push && !load) begin
                count <= count + 1'b1;
            end else if (!push && load) begin
                count <= count - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu32_issue_pipe.sv
// tb_alu32_issue_pipe: table-driven, directed and randomized checks
// of alu32_issue_pipe against a transaction-level reference model.

module tb_alu32_issue_pipe;
    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic [2:0]  in_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_zero;
    logic        out_negative;
    logic [1:0]  ovf_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    alu32_issue_pipe #(.DEPTH(2), .CNT_W(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_A         (in_A),
        .in_B         (in_B),
        .in_control   (in_control),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .out_negative (out_negative),
        .ovf_count    (ovf_count),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
        logic [31:0] res;
        logic        ov;
        logic        z;
        logic        n;
    } vec_t;

    vec_t tbl [10];

    logic [34:0] q [$];
    int          mcnt;
    logic        prev_stall;
    logic [34:0] held;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] c);
        in_valid   = v;
        in_A       = a;
        in_B       = b;
        in_control = c;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Reference ALU: signed arithmetic in 64 bits, overflow when the
    // true result falls outside the 32-bit signed range.
    function automatic logic [34:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [2:0]  c);
        longint      sa;
        longint      sb;
        longint      r;
        longint      mx;
        logic [31:0] res;
        logic        ov;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        mx  = 64'sd2147483647;
        r   = 0;
        ov  = 1'b0;
        res = '0;
        case (c)
            3'd2: r = sa + sb;
            3'd3: r = sa - sb;
            default: r = 0;
        endcase
        case (c)
            3'd2, 3'd3: begin
                res = r[31:0];
                ov  = (r > mx) || (r < -mx - 1);
            end
            3'd4: res = a & b;
            3'd5: res = a | b;
            3'd6: res = ~(a | b);
            3'd7: res = a ^ b;
            default: res = '0;
        endcase
        return {ov, (res == 32'd0), res[31], res};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Sampled just before the active edge: handshakes seen here
    // complete at the coming edge.
    task automatic sample();
        logic [34:0] got;
        logic [34:0] e;
        got = {out_overflow, out_zero, out_negative, out_result};
        if (prev_stall) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_hold", 64'(got), 64'(held));
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious", 64'(got), 64'h0);
                errors += (got == 0) ? 1 : 0;
            end else begin
                e = q.pop_front();
                chk("rnd_out", 64'(got), 64'(e));
                if (e[34] && mcnt < 3) mcnt++;
            end
        end
        prev_stall = out_valid && !out_ready;
        held       = got;
        if (in_valid && in_ready) begin
            q.push_back(model(in_A, in_B, in_control));
        end
    endtask

    initial begin
        tbl[0] = '{32'd8, 32'd4, 3'd2,
                   32'h0000_000C, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'h7FFF_FFFF, 32'd1, 3'd2,
                   32'h8000_0000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{32'd0, 32'd1, 3'd3,
                   32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{32'h8000_0000, 32'd1, 3'd3,
                   32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'd4,
                   32'h0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{32'h1234_0000, 32'h0000_5678, 3'd5,
                   32'h1234_5678, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'd0, 32'd0, 3'd6,
                   32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 3'd7,
                   32'h0, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{32'hFFFF_FFFF, 32'd1, 3'd2,
                   32'h0, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{32'd5, 32'd5, 3'd3,
                   32'h0, 1'b0, 1'b1, 1'b0};

        reset      = 1'b1;
        out_ready  = 1'b0;
        prev_stall = 1'b0;
        held       = '0;
        mcnt       = 0;
        drive(1'b0, 32'd0, 32'd0, 3'd0);
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(ovf_count), 64'd0);
        chk("rst_res", 64'(out_result), 64'd0);
        reset = 1'b0;

        // single op, minimum latency
        out_ready = 1'b1;
        drive(1'b1, 32'd8, 32'd4, 3'd2);
        tick();
        drive(1'b0, 32'd0, 32'd0, 3'd0);
        chk("lat_early", 64'(out_valid), 64'd0);
        tick();
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_res", 64'(out_result), 64'hC);
        chk("lat_flags",
            64'({out_overflow, out_zero, out_negative}), 64'd0);
        tick();
        chk("lat_idle", 64'(out_valid), 64'd0);
        chk("lat_hold", 64'(out_result), 64'hC);

        // back-to-back stream
        drive(1'b1, 32'd3, 32'd5, 3'd2);
        tick();
        drive(1'b1, 32'd2, 32'd5, 3'd3);
        tick();
        chk("b2b_r0", 64'(out_result), 64'h8);
        drive(1'b1, 32'h5, 32'h6, 3'd7);
        tick();
        chk("b2b_r1", 64'(out_result), 64'hFFFF_FFFD);
        chk("b2b_n1", 64'(out_negative), 64'd1);
        drive(1'b0, 32'd0, 32'd0, 3'd0);
        tick();
        chk("b2b_r2", 64'(out_result), 64'h3);
        chk("b2b_v2", 64'(out_valid), 64'd1);
        tick();
        chk("b2b_end", 64'(out_valid), 64'd0);

        // backpressure fill and drain
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd1, 3'd2);
        tick();
        drive(1'b1, 32'd2, 32'd2, 3'd2);
        tick();
        chk("bp_first", 64'(out_result), 64'd2);
        chk("bp_rdy1", 64'(in_ready), 64'd1);
        drive(1'b1, 32'd3, 32'd3, 3'd2);
        tick();
        drive(1'b0, 32'd0, 32'd0, 3'd0);
        chk("bp_full", 64'(in_ready), 64'd0);
        chk("bp_hold1", 64'(out_result), 64'd2);
        tick();
        chk("bp_hold2", 64'(out_result), 64'd2);
        chk("bp_vhold", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        drive(1'b1, 32'd9, 32'd9, 3'd2);
        #1;
        chk("bp_nopop", 64'(in_ready), 64'd0);
        drive(1'b0, 32'd0, 32'd0, 3'd0);
        tick();
        chk("bp_d1", 64'(out_result), 64'd4);
        chk("bp_rdy2", 64'(in_ready), 64'd1);
        tick();
        chk("bp_d2", 64'(out_result), 64'd6);
        tick();
        chk("bp_dv", 64'(out_valid), 64'd0);
        chk("bp_busy", 64'(busy), 64'd0);

        // overflow counting
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 32'h4000_0000, 32'h4000_0000, 3'd2);
        tick();
        drive(1'b1, 32'd16, 32'd16, 3'd3);
        tick();
        chk("ov_res", 64'(out_result), 64'h8000_0000);
        chk("ov_flags",
            64'({out_overflow, out_zero, out_negative}), 64'b101);
        chk("ov_cnt1", 64'(ovf_count), 64'd1);
        drive(1'b0, 32'd0, 32'd0, 3'd0);
        tick();
        chk("ov_sub", 64'(out_result), 64'd0);
        chk("ov_zero",
            64'({out_overflow, out_zero, out_negative}), 64'b010);
        chk("ov_cnt2", 64'(ovf_count), 64'd1);

        // saturation of the 2-bit counter
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 32'h8000_0000, 3'd2);
        tick();
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) drive(1'b0, 32'd0, 32'd0, 3'd0);
            tick();
            chk("sat_res", 64'(out_result), 64'd0);
            chk("sat_flags",
                64'({out_overflow, out_zero, out_negative}),
                64'b110);
            chk("sat_cnt", 64'(ovf_count),
                64'((k > 3) ? 3 : k));
        end

        // reset with queued and held work
        do_reset();
        drive(1'b1, 32'h7FFF_FFFF, 32'd1, 3'd2);
        tick();
        tick();
        tick();
        drive(1'b0, 32'd0, 32'd0, 3'd0);
        chk("mr_pre_full", 64'(in_ready), 64'd0);
        chk("mr_pre_cnt", 64'(ovf_count), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_ready", 64'(in_ready), 64'd1);
        chk("mr_cnt", 64'(ovf_count), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mr_stale", 64'(out_valid), 64'd0);
        end

        // vector table
        do_reset();
        for (int i = 0; i < 10; i++) begin
            out_ready = 1'b1;
            drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].c);
            tick();
            drive(1'b0, 32'd0, 32'd0, 3'd0);
            tick();
            chk("tbl_valid", 64'(out_valid), 64'd1);
            chk("tbl_res", 64'(out_result), 64'(tbl[i].res));
            chk("tbl_flags",
                64'({out_overflow, out_zero, out_negative}),
                64'({tbl[i].ov, tbl[i].z, tbl[i].n}));
        end
        tick();
        chk("tbl_cnt", 64'(ovf_count), 64'd2);

        // randomized traffic against the reference model
        do_reset();
        q.delete();
        mcnt       = 0;
        prev_stall = 1'b0;
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, pick(), pick(),
                  3'($urandom_range(2, 7)));
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clock);
            sample();
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 3'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            @(negedge clock);
            sample();
            tick();
        end
        chk("drain_left", 64'(q.size()), 64'd0);
        tick();
        chk("rnd_busy", 64'(busy), 64'd0);
        chk("rnd_cnt", 64'(ovf_count), 64'(mcnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu32_issue_pipe.md
Name: alu32_issue_pipe

Overview:
- Sequential issue/retire wrapper directly upstream and downstream of the combinational 32-bit ALU (alu32).
- Buffers incoming {A, B, control} operations in a small FIFO with a valid/ready handshake.
- Drives the FIFO head into an internal alu32 instance and registers its result and flags into a held output stage with its own valid/ready handshake.
- Maintains a saturating count of overflowing results for the datapath status logic.

Parameters:
- DEPTH, 2, input FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- in_valid  input  1  an operation is offered on in_A, in_B, in_control.
- in_ready  output  1  FIFO can accept; equals !full.
- in_A  input  32  operand A.
- in_B  input  32  operand B.
- in_control  input  3  ALU op code: ADD=2, SUB=3, AND=4, OR=5, NOR=6, XOR=7.
- out_valid  output  1  registered result is present.
- out_ready  input  1  consumer takes the result this cycle.
- out_result  output  32  registered ALU out.
- out_overflow  output  1  registered ALU overflow.
- out_zero  output  1  registered ALU zero.
- out_negative  output  1  registered ALU negative.
- ovf_count  output  CNT_W  saturating count of retired results with overflow=1.
- busy  output  1  FIFO non-empty or out_valid.

Behaviour:
- Reset (synchronous): FIFO empty with pointers at 0; out_valid=0; out_result/out_overflow/out_zero/out_negative=0; ovf_count=0; busy=0; in_ready=1. Reset mid-operation discards all queued and held operations with no partial results.
- Push: when in_valid && in_ready at an edge, write {A, B, control} at the write pointer; pointer wraps modulo DEPTH. Full and empty are derived from a DEPTH+1-state occupancy count.
- Full-cycle rule: in_ready is 0 while full, even if a pop occurs in the same cycle; no push-on-pop when full.
- Head: FIFO head feeds alu32 combinationally.
- Load condition: !empty && (!out_valid || out_ready).
- Load action (at the edge): capture alu32 out/overflow/zero/negative into the output registers, pop the head, set out_valid=1.
- Output idle: if out_valid && out_ready and the FIFO is empty, out_valid goes to 0 and the data registers hold their last values.
- Stall: while out_valid && !out_ready, all output registers are held stable and no pop occurs.
- Simultaneous push and pop when not full: both occur; occupancy is unchanged.
- Latency: operation accepted at edge N is written to the FIFO. At the earliest it loads at edge N+1 and is visible with out_valid=1 after N+1. There is no bypass from in_* directly to the output.
- Throughput: one result per cycle when out_ready is held at 1.
- Arithmetic: exactly alu32 semantics; 32-bit wrap; signed overflow for ADD/SUB only.
- Unused op codes 0 and 1: passed to alu32 unchanged; retired like any other op.
- ovf_count: +1 on each load with overflow=1; saturates at 2^CNT_W-1 with no wrap; cleared only by reset.
- Ordering: strictly FIFO; no reordering or drop except on reset.

Test Plan:
- After reset, push A=8, B=4, ctrl=ADD with out_ready=1 -> one cycle after accept: out_valid=1, out_result=0x0000000C, overflow/zero/negative=0,0,0; then out_valid=0.
- Back-to-back stream at out_ready=1: ADD 3+5, SUB 2-5, XOR 0x5^0x6 -> results 0x8, 0xFFFFFFFD (neg=1), 0x3 on three consecutive cycles.
- Backpressure with out_ready=0, DEPTH=2, push three ops -> in_ready=0 after the third accept. Output holds the first result stable. Releasing out_ready drains the ops in order, one per cycle, with no loss or duplication.
- Overflow: ADD 0x40000000+0x40000000 -> out_result=0x80000000, overflow=1, negative=1, ovf_count=1. Then SUB 16-16 -> 0, zero=1, ovf_count stays 1.
- Saturation (CNT_W=2): retire five overflowing ADD 0x80000000+0x80000000 -> each result 0, zero=1, overflow=1; ovf_count 1,2,3,3,3.
- Reset mid-operation: FIFO holds two ops and out_valid=1, assert reset one cycle -> next cycle out_valid=0, busy=0, in_ready=1, ovf_count=0; no stale result appears afterward.
